// File: rtl/io_write_capture.sv
// Purpose : captures CPU writes to the $E8xx I/O page into a FIFO that the Pi drains.
// Latency : a capture or pop in cycle N is visible on fifo_count/fifo_data_out in N+1.
// Backpress: none towards the CPU; a capture while full (with no pop) is dropped and sets sticky overflow.
//
// Ports
//   clk               system clock, all state changes on its rising edge
//   reset_b           asynchronous active-low reset, clears the FIFO immediately
//   bus_addr[15:0]    CPU address bus
//   bus_data_in[7:0]  CPU write data
//   bus_rw_b          CPU read/not-write (0 = write)
//   io_select         CPU is addressing the I/O page
//   cpu_write_strobe  write strobe, rising edge starts one capture
//   pi_read_strobe    Pi pop request, rising edge pops one entry
//   pi_clear_overflow one-cycle request to clear the overflow flag
//   fifo_data_out     head entry {bus_addr[7:0], data}, 16'hFFFF when empty
//   fifo_empty        FIFO holds no entries
//   fifo_count        number of stored entries (0..DEPTH)
//   overflow          sticky flag: a capture was dropped because the FIFO was full
module io_write_capture #(
  parameter int DEPTH = 16  // power of two, 4..64
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic [15:0]              bus_addr,
  input  logic [7:0]               bus_data_in,
  input  logic                     bus_rw_b,
  input  logic                     io_select,
  input  logic                     cpu_write_strobe,
  input  logic                     pi_read_strobe,
  input  logic                     pi_clear_overflow,
  output logic [15:0]              fifo_data_out,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  IO_PAGE  = 8'hE8;

  // Strobe edge history
  logic wr_stb_q;
  logic rd_stb_q;

  // FIFO state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          ovf_q,    ovf_d;

  // Storage carries no reset; the empty check below masks stale contents.
  logic [15:0] mem_q [DEPTH];

  logic qualified;
  logic capture;
  logic pop_req;
  logic is_empty;
  logic is_full;
  logic do_pop;
  logic do_push;
  logic drop;

  assign qualified = io_select && !bus_rw_b && (bus_addr[15:8] == IO_PAGE);

  // Rising-edge detection: a strobe held high produces a single event.
  // Edge history follows the raw strobe so an unqualified rising edge is
  // consumed and cannot later turn into a capture mid-pulse.
  assign capture = cpu_write_strobe && !wr_stb_q && qualified;
  assign pop_req = pi_read_strobe && !rd_stb_q;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  // Popping an empty FIFO is silently ignored, which also makes a
  // simultaneous capture+pop on empty a plain capture.
  assign do_pop  = pop_req && !is_empty;
  // When full, a coincident pop frees the slot the capture needs.
  assign do_push = capture && (!is_full || do_pop);
  assign drop    = capture && is_full && !do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A dropped capture wins over a coincident clear request.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (pi_clear_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_stb_q <= cpu_write_strobe;
      rd_stb_q <= pi_read_strobe;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= {bus_addr[7:0], bus_data_in};
    end
  end

  assign fifo_empty    = is_empty;
  assign fifo_count    = count_q;
  assign overflow      = ovf_q;
  assign fifo_data_out = is_empty ? 16'hFFFF : mem_q[rd_ptr_q];

endmodule

// File: doc/io_write_capture.md
IO_WRITE_CAPTURE -- requirements
Module: io_write_capture

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entry count; SHALL be a power of two, 4..64.
REQ-002 clk  input  1  system clock; all state SHALL change only on rising clk.
REQ-003 reset_b  input  1  reset, asynchronous and active-low.
REQ-004 bus_addr  input  16  CPU address bus.
REQ-005 bus_data_in  input  8  CPU data bus during writes.
REQ-006 bus_rw_b  input  1  CPU read/not-write; 0 = write.
REQ-007 io_select  input  1  high while the CPU addresses the I/O page.
REQ-008 cpu_write_strobe  input  1  write strobe, synchronous to clk, high for >=1 cycle per CPU write.
REQ-009 pi_read_strobe  input  1  Pi pop request, synchronous to clk, high for >=1 cycle per pop.
REQ-010 pi_clear_overflow  input  1  one-cycle-high request to clear overflow.
REQ-011 fifo_data_out  output  16  head entry: [15:8] = bus_addr[7:0], [7:0] = data.
REQ-012 fifo_empty  output  1  high when the FIFO holds no entries.
REQ-013 fifo_count  output  log2(DEPTH)+1  number of stored entries.
REQ-014 overflow  output  1  sticky: a capture was dropped because the FIFO was full.

Function
REQ-015 Qualified write SHALL mean io_select=1, bus_rw_b=0, bus_addr[15:8]=8'hE8, all in the capture cycle.
REQ-016 Capture event SHALL occur in cycle N when cpu_write_strobe=1 in N, was 0 in N-1, and the write is qualified in N; a strobe held high SHALL yield exactly one capture.
REQ-017 Pop event SHALL occur in cycle N when pi_read_strobe=1 in N and was 0 in N-1; one pop per rising edge.
REQ-018 On capture, {bus_addr[7:0], bus_data_in} SHALL be written at the tail at the end of cycle N; fifo_count and fifo_empty SHALL reflect it in N+1.
REQ-019 fifo_data_out SHALL show the oldest entry whenever fifo_empty=0, and 16'hFFFF when empty.
REQ-020 On pop with fifo_count>0, the head SHALL advance at the end of cycle N; the next entry (or 16'hFFFF) SHALL appear in N+1.
REQ-021 Pop with fifo_count=0 SHALL be ignored, with no state change and no error flag.
REQ-022 Capture and pop in the same cycle with 0<fifo_count<DEPTH: both SHALL occur; fifo_count unchanged.
REQ-023 Capture and pop in the same cycle with fifo_count=0: only the capture SHALL occur; count becomes 1.
REQ-024 Capture with fifo_count=DEPTH and no pop: entry SHALL be dropped, FIFO contents unchanged, overflow set in N+1.
REQ-025 Capture and pop in the same cycle with fifo_count=DEPTH: both SHALL occur; count stays DEPTH; overflow unchanged.
REQ-026 pi_clear_overflow=1 SHALL clear overflow in the next cycle; if an overflow event coincides, set SHALL win.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; entry order SHALL be strict FIFO across wrap.
REQ-028 Unqualified writes (reads, other pages, io_select=0) SHALL never alter state.

Reset
REQ-029 While reset_b=0: fifo_count=0, fifo_empty=1, overflow=0, fifo_data_out=16'hFFFF, pointers=0, strobe edge-history registers=0.
REQ-030 Reset assertion mid-operation SHALL discard all entries immediately, without waiting for clk.
REQ-031 A strobe already high when reset_b deasserts SHALL count as a rising edge on the first clk.
REQ-032 Storage array contents need no reset; they SHALL be unobservable while empty.

Verification
REQ-033 Write $E810 <- 8'h05 (strobe high 3 cycles) -> one entry; fifo_data_out=16'h1005, fifo_count=1 next cycle.
REQ-034 Writes to $E000, $E900, and a read of $E812 -> fifo_empty stays 1, fifo_count=0.
REQ-035 DEPTH+1 writes $E800..$E810 with data 8'h00..8'h10 -> count=16, overflow=1; pops return 16'h0000..16'h0F0F in order, then 16'hFFFF.
REQ-036 With FIFO full, capture and pop in the same cycle -> count stays 16, overflow stays 0, head advances; pop with FIFO empty -> no change.
REQ-037 Three entries queued, reset_b pulsed low between clk edges -> fifo_empty=1, count=0, overflow=0 immediately.
REQ-038 pi_clear_overflow coincident with a full-FIFO capture -> overflow=1; a clear in the following cycle -> overflow=0.
